// File: rtl/pcpi_ctrl_pkg.sv
// Shared types and widths for the nibble-serial PCPI issue controller.
package pcpi_ctrl_pkg;

  localparam int unsigned NIBBLE_W               = 4;
  localparam int unsigned WORD_W                 = 32;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_ISSUE,
    ST_UNLOAD
  } pcpi_state_e;

endpackage

// File: rtl/pcpi_issue_ctrl_if.sv
// Host-side nibble channels and coprocessor-side PCPI handshake for pcpi_issue_ctrl.
interface pcpi_issue_ctrl_if;
  import pcpi_ctrl_pkg::*;

  logic                nib_valid;
  logic [NIBBLE_W-1:0] nib_data;
  logic                nib_ack;
  logic                abort;
  logic                pcpi_valid;
  logic [WORD_W-1:0]   pcpi_insn;
  logic                pcpi_ready;
  logic                pcpi_wr;
  logic                pcpi_wait;
  logic [WORD_W-1:0]   pcpi_rd;
  logic [NIBBLE_W-1:0] res_nib;
  logic                res_valid;
  logic                res_ack;
  logic                busy;
  logic                done;
  logic                err_timeout;

  modport slave (
    input  nib_valid, nib_data, abort, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, res_ack,
    output nib_ack, pcpi_valid, pcpi_insn, res_nib, res_valid, busy, done, err_timeout
  );

  modport master (
    output nib_valid, nib_data, abort, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, res_ack,
    input  nib_ack, pcpi_valid, pcpi_insn, res_nib, res_valid, busy, done, err_timeout
  );
endinterface

// File: rtl/pcpi_timeout_timer.sv
// Counts consecutive run cycles; expired flags the cycle in which the count reaches TIMEOUT_CYCLES.
module pcpi_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clear,
  output logic expired
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/pcpi_issue_ctrl.sv
// Assembles a PCPI instruction from host nibbles, issues it, and streams any result back as nibbles.
module pcpi_issue_ctrl
  import pcpi_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned NIBBLES        = WORD_W / NIBBLE_W
) (
  input logic              clk,
  input logic              rst_n,
  pcpi_issue_ctrl_if.slave bus
);
  localparam int unsigned      CNT_W    = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  pcpi_state_e       state, state_nxt;
  logic [CNT_W-1:0]  nib_cnt, res_cnt;
  logic [WORD_W-1:0] insn_q, result_q;
  logic              nib_ack_q, done_q, err_q;
  logic              accept, capture, finish_nowr, res_adv, res_last, tmo_hit;
  logic              tmr_run, tmr_clear, expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nxt;
  end

  // Priority: abort, then ready, then timeout.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    capture     = 1'b0;
    finish_nowr = 1'b0;
    res_adv     = 1'b0;
    res_last    = 1'b0;
    tmo_hit     = 1'b0;
    if (bus.abort) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bus.nib_valid) begin
            accept = 1'b1;
            if (nib_cnt == LAST_NIB) state_nxt = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.pcpi_ready) begin
            if (bus.pcpi_wr) begin
              capture   = 1'b1;
              state_nxt = ST_UNLOAD;
            end else begin
              finish_nowr = 1'b1;
              state_nxt   = ST_LOAD;
            end
          end else if (expired) begin
            tmo_hit   = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
        ST_UNLOAD: begin
          if (bus.res_ack) begin
            res_adv = 1'b1;
            if (res_cnt == LAST_NIB) begin
              res_last  = 1'b1;
              state_nxt = ST_LOAD;
            end
          end
        end
        default: state_nxt = ST_LOAD;
      endcase
    end
  end

  assign tmr_run   = (state == ST_ISSUE) && !bus.pcpi_wait;
  assign tmr_clear = (state != ST_ISSUE) || bus.pcpi_wait || bus.abort;

  pcpi_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (tmr_run),
    .clear   (tmr_clear),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt   <= '0;
      res_cnt   <= '0;
      insn_q    <= '0;
      result_q  <= '0;
      nib_ack_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      nib_ack_q <= accept;
      done_q    <= finish_nowr || res_last;
      if (bus.abort) begin
        nib_cnt <= '0;
        res_cnt <= '0;
      end else begin
        if (accept) begin
          insn_q[NIBBLE_W*nib_cnt +: NIBBLE_W] <= bus.nib_data;
          nib_cnt <= (nib_cnt == LAST_NIB) ? '0 : nib_cnt + CNT_W'(1);
          if (nib_cnt == '0) err_q <= 1'b0;
        end
        if (tmo_hit) err_q <= 1'b1;
        if (capture) begin
          result_q <= bus.pcpi_rd;
          res_cnt  <= '0;
        end
        if (res_adv) res_cnt <= res_last ? '0 : res_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.nib_ack     = nib_ack_q;
  assign bus.pcpi_valid  = (state == ST_ISSUE);
  assign bus.pcpi_insn   = insn_q;
  assign bus.res_valid   = (state == ST_UNLOAD);
  assign bus.res_nib     = bus.res_valid ? result_q[NIBBLE_W*res_cnt +: NIBBLE_W] : '0;
  assign bus.busy        = (state != ST_LOAD);
  assign bus.done        = done_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Randomized transaction-level bench for pcpi_issue_ctrl with a word/nibble reference model.
module tb_pcpi_issue_ctrl;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   exp_err = 1'b0;
  logic [31:0] exp_insn = '0;

  pcpi_issue_ctrl_if bus ();

  pcpi_issue_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .NIBBLES        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.nib_valid  = 1'b0;
    bus.nib_data   = '0;
    bus.abort      = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_rd    = '0;
    bus.res_ack    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.pcpi_valid), 0);
    check({tag, "_insn"}, bus.pcpi_insn, 0);
    check({tag, "_ack"}, 32'(bus.nib_ack), 0);
    check({tag, "_resv"}, 32'(bus.res_valid), 0);
    check({tag, "_resn"}, 32'(bus.res_nib), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_err"}, 32'(bus.err_timeout), 0);
  endtask

  // Feeds the eight nibbles of word LSB first, with random idle gaps up to max_gap.
  task automatic load_word(input logic [31:0] word, input int max_gap);
    int acks;
    int gap;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        step();
        acks += int'(bus.nib_ack);
        check("load_idle_valid", 32'(bus.pcpi_valid), 0);
      end
      bus.nib_valid = 1'b1;
      bus.nib_data  = word[4*k +: 4];
      step();
      bus.nib_valid = 1'b0;
      acks += int'(bus.nib_ack);
      if (k == 0) begin
        exp_err = 1'b0;
        check("err_clear_first_nib", 32'(bus.err_timeout), 0);
      end
      if (k < 7) begin
        check("valid_before_8th", 32'(bus.pcpi_valid), 0);
        check("busy_in_load", 32'(bus.busy), 0);
      end else begin
        check("valid_after_8th", 32'(bus.pcpi_valid), 1);
        check("insn_word", bus.pcpi_insn, word);
      end
    end
    exp_insn = word;
    check("nib_ack_count", acks, 8);
  endtask

  // Random wait pattern ahead of a ready at ready_at; timeout predicted by scanning for TMO idle cycles.
  task automatic run_issue(input int ready_at, input bit wr, input logic [31:0] rd, input int mode);
    bit w[64];
    int run_len;
    int exit_at;
    bit timed_out;
    bit rdy;
    exit_at   = ready_at;
    timed_out = 1'b0;
    run_len   = 0;
    for (int i = 0; i <= ready_at; i++) begin
      w[i] = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : ($urandom_range(7, 0) == 0);
      run_len = w[i] ? 0 : run_len + 1;
      if (i < ready_at && run_len >= TMO) begin
        exit_at   = i;
        timed_out = 1'b1;
        break;
      end
    end
    for (int i = 0; i <= exit_at; i++) begin
      check("issue_valid", 32'(bus.pcpi_valid), 1);
      check("issue_insn_stable", bus.pcpi_insn, exp_insn);
      check("issue_nib_ack", 32'(bus.nib_ack), (i == 0) ? 1 : 0);
      rdy = !timed_out && (i == ready_at);
      bus.pcpi_wait  = w[i];
      bus.pcpi_ready = rdy;
      bus.pcpi_wr    = rdy ? wr : 1'($urandom_range(1, 0));
      bus.pcpi_rd    = rdy ? rd : $urandom();
      bus.nib_valid  = 1'($urandom_range(1, 0));
      bus.nib_data   = 4'($urandom());
      step();
    end
    clear_inputs();
    check("exit_valid_low", 32'(bus.pcpi_valid), 0);
    check("exit_insn_kept", bus.pcpi_insn, exp_insn);
    if (timed_out) begin
      exp_err = 1'b1;
      check("tmo_busy", 32'(bus.busy), 0);
      check("tmo_done", 32'(bus.done), 0);
      check("tmo_resv", 32'(bus.res_valid), 0);
    end else if (wr) begin
      check("wr_resv", 32'(bus.res_valid), 1);
      check("wr_done", 32'(bus.done), 0);
    end else begin
      check("nowr_done", 32'(bus.done), 1);
      check("nowr_resv", 32'(bus.res_valid), 0);
      check("nowr_busy", 32'(bus.busy), 0);
      step();
      check("nowr_done_pulse", 32'(bus.done), 0);
    end
    check("err_flag", 32'(bus.err_timeout), 32'(exp_err));
  endtask

  task automatic unload(input logic [31:0] rd, input int max_gap);
    int gap;
    for (int j = 0; j < 8; j++) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        step();
        check("unload_hold_nib", 32'(bus.res_nib), 32'(rd[4*j +: 4]));
        check("unload_hold_done", 32'(bus.done), 0);
      end
      check("unload_resv", 32'(bus.res_valid), 1);
      check("unload_nib", 32'(bus.res_nib), 32'(rd[4*j +: 4]));
      bus.res_ack = 1'b1;
      step();
      bus.res_ack = 1'b0;
    end
    check("unload_end_resv", 32'(bus.res_valid), 0);
    check("unload_end_done", 32'(bus.done), 1);
    check("unload_end_busy", 32'(bus.busy), 0);
    step();
    check("unload_done_pulse", 32'(bus.done), 0);
  endtask

  initial begin
    logic [31:0] w, rd;
    int ready_at;
    bit wr;
    clear_inputs();
    #3;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reference instruction, then a 0x87654321 result acked every cycle
    load_word(32'h2000_0033, 0);
    check("ref_insn", bus.pcpi_insn, 32'h2000_0033);
    rd = 32'h8765_4321;
    run_issue(3, 1'b1, rd, 2);
    unload(rd, 0);

    // Silent coprocessor times out; err survives an abort, clears on next first nibble
    load_word($urandom(), 1);
    run_issue(40, 1'b0, '0, 0);
    check("tmo_err_set", 32'(bus.err_timeout), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_keeps_err", 32'(bus.err_timeout), 1);

    // Long wait stretch holds off the timeout, then completes without a write
    load_word($urandom(), 0);
    check("err_cleared", 32'(bus.err_timeout), 0);
    run_issue(40, 1'b0, '0, 1);

    // Abort after five nibbles beats a same-cycle nibble; partial word kept
    w = $urandom();
    for (int k = 0; k < 5; k++) begin
      bus.nib_valid = 1'b1;
      bus.nib_data  = w[4*k +: 4];
      step();
    end
    exp_insn[19:0] = w[19:0];
    bus.nib_data = 4'hA;
    bus.abort    = 1'b1;
    step();
    clear_inputs();
    check("abort_nib_ack", 32'(bus.nib_ack), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_insn_kept", bus.pcpi_insn, exp_insn);
    load_word(32'hFFFF_FFFF, 0);
    run_issue(2, 1'b0, '0, 2);

    // Abort mid-unload; next result must restart at nibble 0
    load_word($urandom(), 0);
    rd = $urandom();
    run_issue(1, 1'b1, rd, 2);
    for (int j = 0; j < 3; j++) begin
      bus.res_ack = 1'b1;
      step();
    end
    bus.res_ack = 1'b0;
    bus.abort   = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_unload_resv", 32'(bus.res_valid), 0);
    check("abort_unload_busy", 32'(bus.busy), 0);
    check("abort_unload_done", 32'(bus.done), 0);
    load_word($urandom(), 0);
    rd = $urandom();
    run_issue(0, 1'b1, rd, 0);
    unload(rd, 2);

    // Abort during ISSUE drops pcpi_valid
    load_word($urandom(), 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_issue_valid", 32'(bus.pcpi_valid), 0);
    check("abort_issue_insn", bus.pcpi_insn, exp_insn);

    // Random transactions
    for (int t = 0; t < 25; t++) begin
      load_word($urandom(), 2);
      ready_at = int'($urandom_range(30, 0));
      wr = 1'($urandom_range(1, 0));
      rd = $urandom();
      run_issue(ready_at, wr, rd, int'($urandom_range(2, 0)));
      if (bus.res_valid) unload(rd, 2);
    end

    // Asynchronous reset while issuing
    load_word($urandom(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid_issue");
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 1'b0;
    step();
    load_word(32'h1234_5678, 0);
    run_issue(5, 1'b0, '0, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pcpi_issue_ctrl.md
PCPI_ISSUE_CTRL -- requirements
Module: pcpi_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, PCPI issue cycles without pcpi_wait before abandoning.
REQ-002 SHALL have parameter NIBBLES, default 8, nibbles per 32-bit word (fixed at 8; other values unsupported).
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 nib_valid  input  1  host presents an instruction nibble.
REQ-007 nib_data  input  4  instruction nibble.
REQ-008 nib_ack  output  1  one-cycle pulse: nibble accepted.
REQ-009 abort  input  1  synchronous soft clear of the current transaction.
REQ-010 pcpi_valid  output  1  instruction offered to coprocessor.
REQ-011 pcpi_insn  output  32  assembled instruction word.
REQ-012 pcpi_ready  input  1  coprocessor completion.
REQ-013 pcpi_wr  input  1  coprocessor returns a result (sampled with pcpi_ready).
REQ-014 pcpi_wait  input  1  coprocessor accepted, timeout suspended.
REQ-015 pcpi_rd  input  32  coprocessor result.
REQ-016 res_nib  output  4  result nibble, LSB nibble first.
REQ-017 res_valid  output  1  res_nib valid.
REQ-018 res_ack  input  1  host consumed res_nib.
REQ-019 busy  output  1  high in every state except LOAD.
REQ-020 done  output  1  one-cycle pulse at transaction end (result unloaded or no-write completion).
REQ-021 err_timeout  output  1  sticky timeout flag.

Function
REQ-022 SHALL implement FSM states LOAD, ISSUE, UNLOAD; LOAD after reset.
REQ-023 LOAD: nib_valid=1 accepts nib_data into pcpi_insn[4k+3:4k] (k = nibble count 0..7) and pulses nib_ack the following cycle; one nibble per cycle maximum.
REQ-024 LOAD: accepting the first nibble (k=0) clears err_timeout.
REQ-025 LOAD: on accepting nibble k=7, count wraps to 0 and the next cycle is ISSUE, with pcpi_valid=1.
REQ-026 ISSUE: pcpi_valid and pcpi_insn SHALL stay stable until exit; nib_valid ignored, nib_ack held 0 in ISSUE/UNLOAD.
REQ-027 ISSUE: timeout counter increments each cycle pcpi_wait=0, clears each cycle pcpi_wait=1; reaching TIMEOUT_CYCLES deasserts pcpi_valid, sets err_timeout, returns to LOAD.
REQ-028 ISSUE: pcpi_ready=1 deasserts pcpi_valid next cycle; ready wins over a same-cycle timeout.
REQ-029 pcpi_ready with pcpi_wr=1 latches pcpi_rd into result register and enters UNLOAD; with pcpi_wr=0 pulses done and enters LOAD.
REQ-030 UNLOAD: res_valid=1, res_nib = result[4j+3:4j]; res_ack advances j; after j=7 ack, res_valid drops, done pulses, enter LOAD.
REQ-031 abort=1 in any state: next cycle LOAD, nibble/result counts 0, pcpi_valid 0, res_valid 0; err_timeout and pcpi_insn retained; abort beats all same-cycle events.

Reset
REQ-032 rst_n low SHALL immediately force: state LOAD, counts 0, pcpi_valid 0, pcpi_insn 0, nib_ack 0, res_valid 0, res_nib 0, busy 0, done 0, err_timeout 0.
REQ-033 Reset mid-ISSUE SHALL drop pcpi_valid asynchronously without waiting for pcpi_ready.

Structure
REQ-034 Shared package pcpi_ctrl_pkg SHALL hold the FSM state type, NIBBLE_W=4, WORD_W=32, default TIMEOUT_CYCLES.
REQ-035 Timeout counter SHALL be sub-module pcpi_timeout_timer (inputs run, clear; output expired).

Verification
REQ-036 Nibbles 0x3,0x3,0x0,0x0,0x0,0x0,0x0,0x2 -> pcpi_insn=0x20000033, pcpi_valid high exactly cycle after 8th accept, 8 nib_ack pulses.
REQ-037 pcpi_ready+pcpi_wr with pcpi_rd=0x8765_4321, res_ack each cycle -> res_nib 1,2,3,4,5,6,7,8, then done one cycle.
REQ-038 No pcpi_wait/pcpi_ready for 16 cycles -> pcpi_valid low, err_timeout=1, state LOAD; next first nibble clears err_timeout.
REQ-039 pcpi_wait high 40 cycles then pcpi_ready, pcpi_wr=0 -> no timeout, done pulse, no res_valid.
REQ-040 abort after 5 nibbles, then 8 new nibbles 0xF..0xF -> pcpi_insn=0xFFFFFFFF issued.
REQ-041 rst_n low during ISSUE -> pcpi_valid 0 before next clk edge; all outputs at reset values.
